// File: rtl/step_divider_pkg.sv
// Shared constants and helpers for the step_divider block.
//   calc_iters : number of compute cycles, ceil(data_width / step)
//   calc_cnt_w : bits needed to hold the values 0..n (at least 1)
//   state_e    : divider FSM state encoding
package step_divider_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    function automatic int calc_iters(input int data_width, input int step);
        return (data_width + step - 1) / step;
    endfunction

    function automatic int calc_cnt_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < (n + 1)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/step_divider_stage.sv
// div_step_stage: combinational block of STEP chained restoring-division
// iterations, MSB first. Iterations at or beyond active_i pass the partial
// remainder through unchanged and leave their quotient bit at 0.
//   rem_i     : incoming partial remainder (DATA_WIDTH+1 bits)
//   bits_i    : next STEP dividend bits, bits_i[STEP-1] consumed first
//   divisor_i : divisor
//   active_i  : number of iterations to perform this cycle (1..STEP)
//   rem_o     : updated partial remainder
//   q_o       : quotient bits, q_o[STEP-1] belongs to the first iteration
module div_step_stage
    import step_divider_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int STEP       = 4,
    parameter int ACT_W      = calc_cnt_w(STEP)
) (
    input  logic [DATA_WIDTH:0]   rem_i,
    input  logic [STEP-1:0]       bits_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    input  logic [ACT_W-1:0]      active_i,
    output logic [DATA_WIDTH:0]   rem_o,
    output logic [STEP-1:0]       q_o
);

    // Chain of restore iterations; the remainder always stays below the
    // divisor, so dropping its top bit when shifting loses nothing.
    always_comb begin
        logic [DATA_WIDTH:0] rem;
        logic [DATA_WIDTH:0] trial;
        rem   = rem_i;
        trial = '0;
        q_o   = '0;
        for (int i = 0; i < STEP; i++) begin
            if (ACT_W'(i) < active_i) begin
                trial = {rem[DATA_WIDTH-1:0], bits_i[STEP-1-i]};
                if (trial >= {1'b0, divisor_i}) begin
                    rem            = trial - {1'b0, divisor_i};
                    q_o[STEP-1-i]  = 1'b1;
                end else begin
                    rem            = trial;
                end
            end else begin
                rem = rem;
            end
        end
        rem_o = rem;
    end

endmodule

// File: rtl/step_divider.sv
// step_divider: sequential unsigned divider, restoring shift-subtract,
// STEP quotient bits per clock, ceil(DATA_WIDTH/STEP) compute cycles.
//   clk, reset          : clock and synchronous active-high reset
//   start               : request pulse, accepted only in IDLE
//   dividend, divisor   : operands, sampled on the accepting edge
//   quotient, remainder : registered results, held until next result
//   done                : result-valid level, cleared when a start is accepted
module step_divider
    import step_divider_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int STEP       = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  done
);

    localparam int N          = calc_iters(DATA_WIDTH, STEP);
    localparam int CNT_W      = calc_cnt_w(N);
    localparam int ACT_W      = calc_cnt_w(STEP);
    // Iterations in the final cycle, and how many stage bits it leaves unused.
    localparam int LAST_ITERS = DATA_WIDTH - (N - 1) * STEP;
    localparam int LAST_SHIFT = STEP - LAST_ITERS;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   dvd_q, dvd_d;      // remaining dividend bits, MSB aligned
    logic [DATA_WIDTH-1:0]   dvs_q, dvs_d;
    logic [DATA_WIDTH:0]     rem_q, rem_d;      // partial remainder
    logic [DATA_WIDTH-1:0]   acc_q, acc_d;      // quotient bits gathered so far
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   quotient_q, quotient_d;
    logic [DATA_WIDTH-1:0]   remainder_q, remainder_d;
    logic                    done_q, done_d;

    logic                    last_s;
    logic [ACT_W-1:0]        active_s;
    logic [DATA_WIDTH:0]     stage_rem_s;
    logic [STEP-1:0]         stage_q_s;
    logic [DATA_WIDTH+STEP-1:0] wide_s;

    assign last_s   = (cnt_q == CNT_W'(1));
    assign active_s = last_s ? ACT_W'(LAST_ITERS) : ACT_W'(STEP);
    assign wide_s   = {acc_q, stage_q_s};

    div_step_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .STEP       (STEP),
        .ACT_W      (ACT_W)
    ) u_stage (
        .rem_i      (rem_q),
        .bits_i     (dvd_q[DATA_WIDTH-1 -: STEP]),
        .divisor_i  (dvs_q),
        .active_i   (active_s),
        .rem_o      (stage_rem_s),
        .q_o        (stage_q_s)
    );

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        done_d      = done_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dvd_d  = dividend;
                    dvs_d  = divisor;
                    rem_d  = '0;
                    acc_d  = '0;
                    cnt_d  = CNT_W'(N);
                    done_d = 1'b0;
                end else begin
                    done_d = done_q;
                end
            end
            ST_BUSY: begin
                rem_d = stage_rem_s;
                dvd_d = dvd_q << STEP;
                cnt_d = cnt_q - CNT_W'(1);
                if (last_s) begin
                    // Drop the stage bits that were not exercised this cycle.
                    quotient_d  = DATA_WIDTH'(wide_s >> LAST_SHIFT);
                    remainder_d = stage_rem_s[DATA_WIDTH-1:0];
                    done_d      = 1'b1;
                end else begin
                    acc_d       = DATA_WIDTH'(wide_s);
                end
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign done      = done_q;

endmodule

// File: tb/tb_step_divider.sv
module tb_step_divider;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] dividend = 16'd0;
    logic [15:0] divisor = 16'd0;

    logic [15:0] q4, r4, q5, r5, q1, r1, q16, r16;
    logic        d4, d5, d1, d16;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    step_divider #(.DATA_WIDTH(16), .STEP(4)) u_dut (
        .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
        .quotient(q4), .remainder(r4), .done(d4));
    step_divider #(.DATA_WIDTH(16), .STEP(5)) u_s5 (
        .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
        .quotient(q5), .remainder(r5), .done(d5));
    step_divider #(.DATA_WIDTH(16), .STEP(1)) u_s1 (
        .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
        .quotient(q1), .remainder(r1), .done(d1));
    step_divider #(.DATA_WIDTH(16), .STEP(16)) u_s16 (
        .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
        .quotient(q16), .remainder(r16), .done(d16));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Start an operation on the STEP=4 instance and wait (bounded) for done.
    task automatic run_div(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] prev_q, input logic [15:0] eq,
                           input logic [15:0] er);
        int cyc;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        chk({tag, "_done_drop"}, {31'd0, d4}, 32'd0);
        chk({tag, "_q_hold"}, {16'd0, q4}, {16'd0, prev_q});
        cyc = 0;
        while (!d4 && cyc < 40) begin
            tick();
            cyc++;
        end
        chk({tag, "_latency"}, cyc, 32'd4);
        chk({tag, "_quot"}, {16'd0, q4}, {16'd0, eq});
        chk({tag, "_rem"}, {16'd0, r4}, {16'd0, er});
    endtask

    initial begin
        int cyc;
        int lat4, lat5, lat1, lat16;
        logic saw_done;

        // Reset held two cycles.
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("reset_quot", {16'd0, q4}, 32'd0);
        chk("reset_rem", {16'd0, r4}, 32'd0);
        chk("reset_done", {31'd0, d4}, 32'd0);

        // Back-to-back operations.
        run_div("d100_4", 16'd100, 16'd4, 16'd0, 16'd25, 16'd0);
        run_div("d50_5", 16'd50, 16'd5, 16'd25, 16'd10, 16'd0);

        // Same division on every STEP variant; let the STEP=1 instance go idle first.
        for (int i = 0; i < 20; i++) tick();
        dividend = 16'd65535;
        divisor  = 16'd12345;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        lat4 = 0; lat5 = 0; lat1 = 0; lat16 = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (d4 && lat4 == 0) lat4 = c;
            if (d5 && lat5 == 0) lat5 = c;
            if (d1 && lat1 == 0) lat1 = c;
            if (d16 && lat16 == 0) lat16 = c;
        end
        chk("big_s4_lat", lat4, 32'd4);
        chk("big_s4_quot", {16'd0, q4}, 32'd5);
        chk("big_s4_rem", {16'd0, r4}, 32'd3810);
        chk("big_s5_lat", lat5, 32'd4);
        chk("big_s5_quot", {16'd0, q5}, 32'd5);
        chk("big_s5_rem", {16'd0, r5}, 32'd3810);
        chk("big_s1_lat", lat1, 32'd16);
        chk("big_s1_quot", {16'd0, q1}, 32'd5);
        chk("big_s1_rem", {16'd0, r1}, 32'd3810);
        chk("big_s16_lat", lat16, 32'd1);
        chk("big_s16_quot", {16'd0, q16}, 32'd5);
        chk("big_s16_rem", {16'd0, r16}, 32'd3810);

        // Boundary operands.
        run_div("div_by_1", 16'd12345, 16'd1, 16'd5, 16'd12345, 16'd0);
        run_div("zero_dvd", 16'd0, 16'd7, 16'd12345, 16'd0, 16'd0);
        run_div("small_dvd", 16'd7, 16'd100, 16'd0, 16'd0, 16'd7);
        run_div("div_by_0", 16'd1000, 16'd0, 16'd0, 16'd65535, 16'd1000);

        // start while busy is ignored.
        dividend = 16'd500;
        divisor  = 16'd3;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        dividend = 16'd0;
        divisor  = 16'd0;
        tick();
        dividend = 16'd9;
        divisor  = 16'd2;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        cyc = 2;
        while (!d4 && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("busy_start_lat", cyc, 32'd4);
        chk("busy_start_quot", {16'd0, q4}, 32'd166);
        chk("busy_start_rem", {16'd0, r4}, 32'd2);

        // Reset mid-division aborts without a result.
        for (int i = 0; i < 20; i++) tick();
        dividend = 16'd1000;
        divisor  = 16'd7;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        tick();
        reset    = 1'b1;
        tick();
        chk("abort_quot", {16'd0, q4}, 32'd0);
        chk("abort_rem", {16'd0, r4}, 32'd0);
        chk("abort_done", {31'd0, d4}, 32'd0);
        reset    = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (d4) saw_done = 1'b1;
        end
        chk("abort_no_done", {31'd0, saw_done}, 32'd0);

        // Fresh start after the abort.
        run_div("after_abort", 16'd1000, 16'd7, 16'd0, 16'd142, 16'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
